sync_fifo_param: RTL and testbench



---
 rtl/sync_fifo_param_if.sv | 35 +++
 rtl/sync_fifo_param.sv | 143 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer handshake and status bundle for sync_fifo_param.
// The master side is the datapath that pushes and pops; the slave side is the FIFO itself.
interface sync_fifo_param_if #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) ();
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                  write_en;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  read_en;
    logic                  clear_err;

    logic [FIFO_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_en, data_in, read_en, clear_err,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  write_en, data_in, read_en, clear_err,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock elastic buffer of any depth >= 2 with occupancy thresholds, sticky
// overflow/underflow flags and either registered or first-word-fall-through reads.
module sync_fifo_param #(
    parameter int FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int AF_THRESH  = FIFO_DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input logic              clk,
    input logic              resetN,
    sync_fifo_param_if.slave fif
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(AF_THRESH);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_THRESH);

    generate
        if (FIFO_WIDTH < 1) begin : g_bad_width
            $error("sync_fifo_param: FIFO_WIDTH must be at least 1");
        end
        if (FIFO_DEPTH < 2) begin : g_bad_depth
            $error("sync_fifo_param: FIFO_DEPTH must be at least 2");
        end
        if (AF_THRESH > FIFO_DEPTH) begin : g_bad_af
            $error("sync_fifo_param: AF_THRESH must not exceed FIFO_DEPTH");
        end
        if (AE_THRESH >= FIFO_DEPTH) begin : g_bad_ae
            $error("sync_fifo_param: AE_THRESH must be below FIFO_DEPTH");
        end
    endgenerate

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          empty_q;
    logic          full_q;
    logic          af_q;
    logic          ae_q;
    logic          ovf_q;
    logic          udf_q;

    logic rd_acc;
    logic wr_acc;
    logic ovf_set;
    logic udf_set;

    // Pointers wrap explicitly so non-power-of-two depths never touch unused slots.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    endfunction

    // Accept decisions use only registered flags; a read never bypasses a same-cycle write.
    always_comb begin
        rd_acc     = fif.read_en & ~empty_q;
        wr_acc     = fif.write_en & (~full_q | rd_acc);
        ovf_set    = fif.write_en & full_q & ~rd_acc;
        udf_set    = fif.read_en & empty_q;
        count_next = count_q;
        if (wr_acc && !rd_acc) begin
            count_next = count_q + CNT_ONE;
        end else if (rd_acc && !wr_acc) begin
            count_next = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_acc) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count_q <= count_next;
            empty_q <= (count_next == '0);
            full_q  <= (count_next == CNT_FULL);
            af_q    <= (count_next >= CNT_AF);
            ae_q    <= (count_next <= CNT_AE);
            // A new error in the same cycle as clear_err wins.
            ovf_q   <= ovf_set | (ovf_q & ~fif.clear_err);
            udf_q   <= udf_set | (udf_q & ~fif.clear_err);
        end
    end

    always_ff @(posedge clk) begin
        if (resetN && wr_acc) begin
            mem[wr_ptr] <= fif.data_in;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign fif.data_out   = mem[rd_ptr];
            assign fif.data_valid = ~empty_q;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] dout_q;
            logic                  dv_q;

            always_ff @(posedge clk) begin
                if (!resetN) begin
                    dout_q <= '0;
                    dv_q   <= 1'b0;
                end else begin
                    dv_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= mem[rd_ptr];
                    end
                end
            end

            assign fif.data_out   = dout_q;
            assign fif.data_valid = dv_q;
        end
    endgenerate

    assign fif.full         = full_q;
    assign fif.empty        = empty_q;
    assign fif.almost_full  = af_q;
    assign fif.almost_empty = ae_q;
    assign fif.count        = count_q;
    assign fif.overflow     = ovf_q;
    assign fif.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: three instances (depth 16 registered, depth 5
// registered, depth 8 FWFT) compared against a queue-based reference model.
module tb_sync_fifo_param;
    typedef struct packed {
        logic [7:0] dout;
        logic       dv;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic [4:0] count;
        logic       ovf;
        logic       udf;
    } obs_t;

    localparam int DEPTH_A [3] = '{16, 5, 8};
    localparam int AF_A    [3] = '{14, 3, 6};
    localparam int AE_A    [3] = '{2, 2, 2};
    localparam int FWFT_A  [3] = '{0, 0, 1};

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(16)) if_std ();
    sync_fifo_param_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(5))  if_d5 ();
    sync_fifo_param_if #(.FIFO_WIDTH(8), .FIFO_DEPTH(8))  if_fw ();

    sync_fifo_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0))
        u_std (.clk(clk), .resetN(resetN), .fif(if_std));
    sync_fifo_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .AF_THRESH(3), .AE_THRESH(2), .FWFT(1'b0))
        u_d5 (.clk(clk), .resetN(resetN), .fif(if_d5));
    sync_fifo_param #(.FIFO_WIDTH(8), .FIFO_DEPTH(8), .AF_THRESH(6), .AE_THRESH(2), .FWFT(1'b1))
        u_fw (.clk(clk), .resetN(resetN), .fif(if_fw));

    obs_t obs_a [3];
    assign obs_a[0] = {if_std.data_out, if_std.data_valid, if_std.full, if_std.empty,
                       if_std.almost_full, if_std.almost_empty, 5'(if_std.count),
                       if_std.overflow, if_std.underflow};
    assign obs_a[1] = {if_d5.data_out, if_d5.data_valid, if_d5.full, if_d5.empty,
                       if_d5.almost_full, if_d5.almost_empty, 5'(if_d5.count),
                       if_d5.overflow, if_d5.underflow};
    assign obs_a[2] = {if_fw.data_out, if_fw.data_valid, if_fw.full, if_fw.empty,
                       if_fw.almost_full, if_fw.almost_empty, 5'(if_fw.count),
                       if_fw.overflow, if_fw.underflow};

    // Reference model: the stored words as a queue plus the visible read register and error bits.
    logic [7:0] mq [3][$];
    logic [7:0] m_dout [3];
    logic       m_dv   [3];
    logic       m_ovf  [3];
    logic       m_udf  [3];

    int n_pass  = 0;
    int n_total = 0;

    localparam obs_t RESET_OBS = '{dout: 8'h00, dv: 1'b0, full: 1'b0, empty: 1'b1, af: 1'b0,
                                   ae: 1'b1, count: 5'd0, ovf: 1'b0, udf: 1'b0};

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            mq[d].delete();
            m_dout[d] = 8'h00;
            m_dv[d]   = 1'b0;
            m_ovf[d]  = 1'b0;
            m_udf[d]  = 1'b0;
        end
    endfunction

    function automatic void model_step(input int d, input logic we, input logic [7:0] din,
                                       input logic re, input logic clr);
        int n;
        bit rd_ok, wr_ok, ovf_set, udf_set;
        n       = mq[d].size();
        rd_ok   = re && (n > 0);
        wr_ok   = we && ((n < DEPTH_A[d]) || rd_ok);
        ovf_set = we && (n == DEPTH_A[d]) && !rd_ok;
        udf_set = re && (n == 0);
        m_dv[d] = rd_ok;
        if (rd_ok) m_dout[d] = mq[d].pop_front();
        if (wr_ok) mq[d].push_back(din);
        m_ovf[d] = ovf_set || (m_ovf[d] && !clr);
        m_udf[d] = udf_set || (m_udf[d] && !clr);
    endfunction

    function automatic obs_t model_obs(input int d);
        obs_t e;
        int   n;
        n       = mq[d].size();
        e       = '0;
        e.count = 5'(n);
        e.empty = (n == 0);
        e.full  = (n == DEPTH_A[d]);
        e.af    = (n >= AF_A[d]);
        e.ae    = (n <= AE_A[d]);
        e.ovf   = m_ovf[d];
        e.udf   = m_udf[d];
        if (FWFT_A[d] != 0) begin
            e.dv   = (n > 0);
            e.dout = (n > 0) ? mq[d][0] : 8'h00;
        end else begin
            e.dv   = m_dv[d];
            e.dout = m_dout[d];
        end
        return e;
    endfunction

    // FWFT data_out is meaningless while nothing is valid, so it is masked out.
    function automatic obs_t dut_obs(input int d);
        obs_t o;
        o = obs_a[d];
        if ((FWFT_A[d] != 0) && !o.dv) o.dout = 8'h00;
        return o;
    endfunction

    task automatic drive(input int d, input logic we, input logic [7:0] din,
                         input logic re, input logic clr);
        case (d)
            0: begin
                if_std.write_en = we; if_std.data_in = din; if_std.read_en = re; if_std.clear_err = clr;
            end
            1: begin
                if_d5.write_en = we; if_d5.data_in = din; if_d5.read_en = re; if_d5.clear_err = clr;
            end
            default: begin
                if_fw.write_en = we; if_fw.data_in = din; if_fw.read_en = re; if_fw.clear_err = clr;
            end
        endcase
    endtask

    task automatic clock_op(input int d, input logic we, input logic [7:0] din,
                            input logic re, input logic clr);
        drive(d, we, din, re, clr);
        @(posedge clk);
        #1;
        model_step(d, we, din, re, clr);
        drive(d, 1'b0, din, 1'b0, 1'b0);
    endtask

    task automatic apply_reset(input int cycles);
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00, 1'b0, 1'b0);
        resetN = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        obs_t o;
        apply_reset(2);
        for (int d = 0; d < 3; d++) begin
            o = dut_obs(d);
            n_total++;
            if (o !== RESET_OBS) $display("FAIL reset dut=%0d actual=%h required=%h", d, o, RESET_OBS);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            o = dut_obs(d);
            n_total++;
            if (o !== RESET_OBS) $display("FAIL reset_idle dut=%0d actual=%h required=%h", d, o, RESET_OBS);
            else n_pass++;
        end
    endtask

    task automatic test_fill_drain();
        obs_t o, e;
        for (int i = 0; i < 16; i++) begin
            clock_op(0, 1'b1, 8'(i + 1), 1'b0, 1'b0);
            o = dut_obs(0); e = model_obs(0);
            n_total++;
            if (o !== e) $display("FAIL fill i=%0d actual=%h required=%h", i, o, e);
            else n_pass++;
            if (i == 12 || i == 13) begin
                n_total++;
                if (o.af !== (i == 13)) $display("FAIL fill_af count=%0d actual=%b required=%b", i + 1, o.af, (i == 13));
                else n_pass++;
            end
        end
        n_total++;
        if (o.full !== 1'b1 || o.count !== 5'd16)
            $display("FAIL fill_full actual full=%b count=%0d required full=1 count=16", o.full, o.count);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            clock_op(0, 1'b0, 8'h00, 1'b1, 1'b0);
            o = dut_obs(0); e = model_obs(0);
            n_total++;
            if (o.dout !== 8'(i + 1) || o.dv !== 1'b1)
                $display("FAIL drain_data i=%0d actual=%h/%b required=%h/1", i, o.dout, o.dv, 8'(i + 1));
            else n_pass++;
            n_total++;
            if (o !== e) $display("FAIL drain i=%0d actual=%h required=%h", i, o, e);
            else n_pass++;
        end
        clock_op(0, 1'b0, 8'h00, 1'b0, 1'b0);
        o = dut_obs(0);
        n_total++;
        if (o.dv !== 1'b0 || o.empty !== 1'b1 || o.dout !== 8'h10)
            $display("FAIL drain_end actual dv=%b empty=%b dout=%h required dv=0 empty=1 dout=10", o.dv, o.empty, o.dout);
        else n_pass++;
    endtask

    task automatic test_full_rw();
        obs_t o, e;
        for (int i = 0; i < 16; i++) clock_op(0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            clock_op(0, 1'b1, 8'($urandom), 1'b1, 1'b0);
            o = dut_obs(0); e = model_obs(0);
            n_total++;
            if (o !== e || o.count !== 5'd16 || o.ovf !== 1'b0)
                $display("FAIL full_rw i=%0d actual=%h required=%h", i, o, e);
            else n_pass++;
        end
        clock_op(0, 1'b1, 8'hEE, 1'b0, 1'b0);
        o = dut_obs(0);
        n_total++;
        if (o.ovf !== 1'b1 || o.count !== 5'd16)
            $display("FAIL overflow_set actual ovf=%b count=%0d required ovf=1 count=16", o.ovf, o.count);
        else n_pass++;
        clock_op(0, 1'b1, 8'hEF, 1'b0, 1'b1);
        o = dut_obs(0);
        n_total++;
        if (o.ovf !== 1'b1) $display("FAIL overflow_set_wins actual=%b required=1", o.ovf);
        else n_pass++;
        clock_op(0, 1'b0, 8'h00, 1'b0, 1'b1);
        o = dut_obs(0); e = model_obs(0);
        n_total++;
        if (o.ovf !== 1'b0 || o !== e) $display("FAIL overflow_clear actual=%h required=%h", o, e);
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            clock_op(0, 1'b0, 8'h00, 1'b1, 1'b0);
            o = dut_obs(0); e = model_obs(0);
            n_total++;
            if (o !== e) $display("FAIL full_drain i=%0d actual=%h required=%h", i, o, e);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        obs_t o, e;
        for (int i = 0; i < 3; i++) clock_op(1, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            clock_op(1, 1'b1, 8'(8'h50 + i), 1'b1, 1'b0);
            o = dut_obs(1); e = model_obs(1);
            n_total++;
            if (o !== e) $display("FAIL wrap_pair i=%0d actual=%h required=%h", i, o, e);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            clock_op(1, 1'b0, 8'h00, 1'b1, 1'b0);
            o = dut_obs(1);
            n_total++;
            if (o.dout !== 8'(8'h59 + i)) $display("FAIL wrap_drain i=%0d actual=%h required=%h", i, o.dout, 8'(8'h59 + i));
            else n_pass++;
        end
        clock_op(1, 1'b1, 8'h77, 1'b1, 1'b0);
        o = dut_obs(1);
        n_total++;
        if (o.udf !== 1'b1 || o.count !== 5'd1 || o.dv !== 1'b0)
            $display("FAIL underflow actual udf=%b count=%0d dv=%b required udf=1 count=1 dv=0", o.udf, o.count, o.dv);
        else n_pass++;
        clock_op(1, 1'b0, 8'h00, 1'b1, 1'b1);
        o = dut_obs(1); e = model_obs(1);
        n_total++;
        if (o !== e || o.dout !== 8'h77 || o.udf !== 1'b0)
            $display("FAIL underflow_clear actual=%h required=%h", o, e);
        else n_pass++;
    endtask

    task automatic test_fwft();
        obs_t o, e;
        clock_op(2, 1'b1, 8'hA5, 1'b0, 1'b0);
        o = dut_obs(2);
        n_total++;
        if (o.dv !== 1'b1 || o.dout !== 8'hA5 || o.empty !== 1'b0)
            $display("FAIL fwft_show actual dv=%b dout=%h empty=%b required dv=1 dout=a5 empty=0", o.dv, o.dout, o.empty);
        else n_pass++;
        clock_op(2, 1'b0, 8'h00, 1'b0, 1'b0);
        o = dut_obs(2);
        n_total++;
        if (o.dv !== 1'b1 || o.dout !== 8'hA5) $display("FAIL fwft_hold actual dv=%b dout=%h required dv=1 dout=a5", o.dv, o.dout);
        else n_pass++;
        clock_op(2, 1'b0, 8'h00, 1'b1, 1'b0);
        o = dut_obs(2); e = model_obs(2);
        n_total++;
        if (o.empty !== 1'b1 || o.dv !== 1'b0 || o !== e)
            $display("FAIL fwft_pop actual=%h required=%h", o, e);
        else n_pass++;
    endtask

    task automatic test_random();
        obs_t o, e;
        logic we, re, clr;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 400; i++) begin
                // Alternate write-heavy and read-heavy phases so full and empty are both reached.
                if (((i / 50) % 2) == 0) begin
                    we = ($urandom_range(0, 99) < 75);
                    re = ($urandom_range(0, 99) < 35);
                end else begin
                    we = ($urandom_range(0, 99) < 35);
                    re = ($urandom_range(0, 99) < 75);
                end
                clr = ($urandom_range(0, 15) == 0);
                clock_op(d, we, 8'($urandom), re, clr);
                o = dut_obs(d); e = model_obs(d);
                n_total++;
                if (o !== e) $display("FAIL random dut=%0d i=%0d actual=%h required=%h", d, i, o, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        apply_reset(1);
        clock_op(0, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) clock_op(0, 1'b1, 8'($urandom), 1'b0, 1'b0);
        o = dut_obs(0);
        n_total++;
        if (o.count !== 5'd7 || o.udf !== 1'b1)
            $display("FAIL pre_reset actual count=%0d udf=%b required count=7 udf=1", o.count, o.udf);
        else n_pass++;
        apply_reset(1);
        o = dut_obs(0);
        n_total++;
        if (o !== RESET_OBS) $display("FAIL reset_mid actual=%h required=%h", o, RESET_OBS);
        else n_pass++;
        clock_op(0, 1'b1, 8'h3C, 1'b0, 1'b0);
        clock_op(0, 1'b0, 8'h00, 1'b1, 1'b0);
        o = dut_obs(0);
        n_total++;
        if (o.dout !== 8'h3C || o.dv !== 1'b1 || o.empty !== 1'b1)
            $display("FAIL reset_readback actual dout=%h dv=%b empty=%b required dout=3c dv=1 empty=1", o.dout, o.dv, o.empty);
        else n_pass++;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_wrap();
        test_fwft();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=%0d checks done required=completion", n_total);
        $fatal(1, "simulation time limit reached");
    end
endmodule
